io_bottom_pad_conditioner: RTL

//  Registered pad-conditioning stage between the chip pins and the bottom I/O tile of the FPGA fabric.

---
 rtl/io_pad_pkg.sv | 13 +
 rtl/io_bottom_pad_conditioner_if.sv | 32 +++
 rtl/pad_debounce_cell.sv | 63 ++++++
 rtl/io_bottom_pad_conditioner.sv | 65 ++++++
 4 files changed

// File: rtl/io_pad_pkg.sv
// Shared constants for the bottom I/O pad conditioner and the fabric wrapper.
package io_pad_pkg;

  localparam int IO_NUM_GPIN        = 8;
  localparam int IO_SYNC_STAGES     = 2;
  localparam int IO_DEBOUNCE_CYCLES = 4;

  // Width of a counter that must hold 0 .. debounce_cycles-1 with headroom.
  function automatic int debounce_cnt_w(input int debounce_cycles);
    return $clog2(debounce_cycles) + 1;
  endfunction

endpackage

// File: rtl/io_bottom_pad_conditioner_if.sv
// Pin-side and tile-side pad signals of the bottom I/O conditioner.
interface io_bottom_pad_conditioner_if
  import io_pad_pkg::*;
#(
  parameter int NUM_IN = IO_NUM_GPIN
);

  logic [NUM_IN-1:0] pad_in;
  logic [0:NUM_IN-1] gpin_o;
  logic [NUM_IN-1:0] in_edge;
  logic              gpout_i;
  logic              pad_out;

  // Chip/board side: drives the raw pins and the tile's GPOUT, observes the rest.
  modport master (
    output pad_in,
    output gpout_i,
    input  gpin_o,
    input  in_edge,
    input  pad_out
  );

  // Conditioner side.
  modport slave (
    input  pad_in,
    input  gpout_i,
    output gpin_o,
    output in_edge,
    output pad_out
  );

endinterface

// File: rtl/pad_debounce_cell.sv
// One input pin: synchroniser chain, debounce counter, stable register, change pulse.
module pad_debounce_cell
  import io_pad_pkg::*;
#(
  parameter int SYNC_STAGES     = IO_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES,
  parameter int CNT_W           = debounce_cnt_w(IO_DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic debounce_en,
  input  logic edge_allow,
  input  logic pad,
  output logic stable,
  output logic edge_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   den_prev;
  logic                   sync;
  logic                   stable_next;

  assign sync = sync_q[SYNC_STAGES-1];

  // Decide the next accepted level and counter; a mode change only clears the count.
  always_comb begin
    stable_next = stable;
    cnt_next    = '0;
    if (debounce_en != den_prev) begin
      stable_next = stable;
    end else if (!debounce_en) begin
      stable_next = sync;
    end else if (sync != stable) begin
      if (cnt == CNT_LAST) begin
        stable_next = sync;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // Synchroniser shift, state update and one-cycle change pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      cnt        <= '0;
      stable     <= 1'b0;
      edge_pulse <= 1'b0;
      den_prev   <= debounce_en;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pad};
      cnt        <= cnt_next;
      stable     <= stable_next;
      edge_pulse <= (stable_next != stable) & edge_allow;
      den_prev   <= debounce_en;
    end
  end

endmodule

// File: rtl/io_bottom_pad_conditioner.sv
// Registered pad conditioning between chip pins and the bottom I/O tile.
module io_bottom_pad_conditioner
  import io_pad_pkg::*;
#(
  parameter int NUM_IN          = IO_NUM_GPIN,
  parameter int SYNC_STAGES     = IO_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES,
  parameter int CNT_W           = debounce_cnt_w(IO_DEBOUNCE_CYCLES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_done,
  input  logic                        debounce_en,
  io_bottom_pad_conditioner_if.slave  pads
);

  logic              cfg_done_q;
  logic              edge_allow;
  logic [NUM_IN-1:0] stable;
  logic [NUM_IN-1:0] edge_w;
  logic [0:NUM_IN-1] gpin_w;

  // A change only pulses when gating is open both before and after the edge,
  // so cfg_done transitions never masquerade as input edges.
  assign edge_allow = cfg_done & cfg_done_q;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_cell
    pad_debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_cell (
      .clk         (clk),
      .reset       (reset),
      .debounce_en (debounce_en),
      .edge_allow  (edge_allow),
      .pad         (pads.pad_in[i]),
      .stable      (stable[i]),
      .edge_pulse  (edge_w[i])
    );
  end

  // Gate the stable levels onto the tile pads until the bitstream is loaded.
  always_comb begin
    gpin_w = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      gpin_w[i] = stable[i] & cfg_done_q;
    end
  end

  assign pads.gpin_o  = gpin_w;
  assign pads.in_edge = edge_w;

  // Configuration-done flag and the registered chip output pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_done_q   <= 1'b0;
      pads.pad_out <= 1'b0;
    end else begin
      cfg_done_q   <= cfg_done;
      pads.pad_out <= pads.gpout_i & cfg_done;
    end
  end

endmodule
